// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: checks start/parity/stop of a SIPO frame and queues the result in a show-ahead FIFO.
// Ports: clk, rst_n, frame_in/frame_valid, parity_mode, two_stop -> out_data/out_*_err/out_valid, out_ready, overrun, clear; optional UART_DEFRAME_STATS_EN adds err_frame_cnt/err_parity_cnt.
module uart_rx_deframer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int FRAME_W = DATA_WIDTH + 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAME_W-1:0]    frame_in,
  input  logic                  frame_valid,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_parity_err,
  output logic                  out_frame_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
`ifdef UART_DEFRAME_STATS_EN
  output logic [15:0]           err_frame_cnt,
  output logic [15:0]           err_parity_cnt,
`endif
  input  logic                  clear
);

  localparam int P  = DATA_WIDTH + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;

  logic                  w_par_en;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_stop1;
  logic                  w_stop2;
  logic                  w_xor;
  logic                  w_ferr;
  logic                  w_perr;

  always_comb begin
    w_par_en = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    w_data   = frame_in[DATA_WIDTH:1];
    w_stop1  = w_par_en ? frame_in[P+1] : frame_in[P];
    w_stop2  = w_par_en ? frame_in[P+2] : frame_in[P+1];
    w_xor    = (^w_data) ^ frame_in[P];
    w_ferr   = frame_in[0] | ~w_stop1 | (two_stop & ~w_stop2);
    w_perr   = 1'b0;
    unique case (parity_mode)
      2'b01:   w_perr = w_xor;
      2'b10:   w_perr = ~w_xor;
      default: w_perr = 1'b0;
    endcase
  end

  logic                  r_s1_v;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic                  r_s1_perr;
  logic                  r_s1_ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_s1_perr <= 1'b0;
      r_s1_ferr <= 1'b0;
    end else begin
      r_s1_v <= frame_valid & ~clear;
      if (frame_valid) begin
        r_s1_data <= w_data;
        r_s1_perr <= w_perr;
        r_s1_ferr <= w_ferr;
      end
    end
  end

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic          r_overrun;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_head;

  always_comb begin
    w_full = (r_wptr[AW] != r_rptr[AW]) &&
             (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    out_valid = (r_wptr != r_rptr);
    w_pop  = out_valid & out_ready;
    // a pop frees the slot this same edge, so a full FIFO still accepts
    w_push = r_s1_v & (~w_full | w_pop);
    w_drop = r_s1_v & w_full & ~w_pop;
    w_head = r_mem[r_rptr[AW-1:0]];
  end

  assign out_data       = w_head[DATA_WIDTH-1:0];
  assign out_frame_err  = w_head[DATA_WIDTH];
  assign out_parity_err = w_head[DATA_WIDTH+1];
  assign overrun        = r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (clear) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= {r_s1_perr, r_s1_ferr, r_s1_data};
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      if (w_drop) r_overrun <= 1'b1;
    end
  end

`ifdef UART_DEFRAME_STATS_EN
  logic [15:0] r_fcnt;
  logic [15:0] r_pcnt;

  // counted at stage 1 so dropped frames are included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt <= '0;
      r_pcnt <= '0;
    end else if (clear) begin
      r_fcnt <= '0;
      r_pcnt <= '0;
    end else if (r_s1_v) begin
      if (r_s1_ferr && r_fcnt != 16'hFFFF) r_fcnt <= r_fcnt + 16'd1;
      if (r_s1_perr && r_pcnt != 16'hFFFF) r_pcnt <= r_pcnt + 16'd1;
    end
  end

  assign err_frame_cnt  = r_fcnt;
  assign err_parity_cnt = r_pcnt;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed self-checking bench for uart_rx_deframer.
// DATA_WIDTH=8, FIFO_DEPTH=4; inputs driven 1ns after the rising edge.
module tb_uart_rx_deframer;
  logic        clk;
  logic        rst_n;
  logic [11:0] frame_in;
  logic        frame_valid;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic [7:0]  out_data;
  logic        out_parity_err;
  logic        out_frame_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        clear;
`ifdef UART_DEFRAME_STATS_EN
  logic [15:0] err_frame_cnt;
  logic [15:0] err_parity_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;

  uart_rx_deframer #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_in(frame_in),
    .frame_valid(frame_valid),
    .parity_mode(parity_mode),
    .two_stop(two_stop),
    .out_data(out_data),
    .out_parity_err(out_parity_err),
    .out_frame_err(out_frame_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun(overrun),
`ifdef UART_DEFRAME_STATS_EN
    .err_frame_cnt(err_frame_cnt),
    .err_parity_cnt(err_parity_cnt),
`endif
    .clear(clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // frame_valid in cycle N; returns in cycle N+2
  task automatic send1(input logic [11:0] f, input logic [1:0] m,
                       input logic ts);
    frame_in = f;
    parity_mode = m;
    two_stop = ts;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    tick();
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // no parity, one stop: stop at bit 9
  function automatic logic [11:0] mkf(input logic [7:0] d);
    return {2'b00, 1'b1, d, 1'b0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    frame_in = '0;
    frame_valid = 1'b0;
    parity_mode = 2'b00;
    two_stop = 1'b0;
    out_ready = 1'b0;
    clear = 1'b0;
    tick();
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_flags valid=%b ovr=%b want 0 0",
               out_valid, overrun);
    else n_pass++;
    n_chk++;
    if (out_data !== 8'h00 || out_parity_err !== 1'b0 ||
        out_frame_err !== 1'b0)
      $display("FAIL reset_head data=%h pe=%b fe=%b want 00 0 0",
               out_data, out_parity_err, out_frame_err);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_even();
    frame_in = 12'h4AA;
    parity_mode = 2'b01;
    two_stop = 1'b0;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0)
      $display("FAIL even_latency valid=%b want 0", out_valid);
    else n_pass++;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'h55)
      $display("FAIL even_data valid=%b data=%h want 1 55",
               out_valid, out_data);
    else n_pass++;
    n_chk++;
    if (out_parity_err !== 1'b0 || out_frame_err !== 1'b0)
      $display("FAIL even_err pe=%b fe=%b want 0 0",
               out_parity_err, out_frame_err);
    else n_pass++;
    pop1();
    n_chk++;
    if (out_valid !== 1'b0)
      $display("FAIL even_pop valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_parity();
    send1(12'h4AA, 2'b10, 1'b0);
    n_chk++;
    if (out_parity_err !== 1'b1 || out_frame_err !== 1'b0)
      $display("FAIL odd_perr pe=%b fe=%b want 1 0",
               out_parity_err, out_frame_err);
    else n_pass++;
    pop1();
    send1(12'h2AA, 2'b00, 1'b0);
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'h55 ||
        out_parity_err !== 1'b0 || out_frame_err !== 1'b0)
      $display("FAIL none_ok v=%b d=%h pe=%b fe=%b want 1 55 0 0",
               out_valid, out_data, out_parity_err, out_frame_err);
    else n_pass++;
    pop1();
    // mode 11 behaves as none
    send1(12'h2AA, 2'b11, 1'b0);
    n_chk++;
    if (out_parity_err !== 1'b0 || out_frame_err !== 1'b0)
      $display("FAIL mode11 pe=%b fe=%b want 0 0",
               out_parity_err, out_frame_err);
    else n_pass++;
    pop1();
  endtask

  task automatic test_frame_err();
    send1(12'h4AA, 2'b01, 1'b1);
    n_chk++;
    if (out_frame_err !== 1'b1 || out_parity_err !== 1'b0)
      $display("FAIL stop2_err fe=%b pe=%b want 1 0",
               out_frame_err, out_parity_err);
    else n_pass++;
    pop1();
    send1(12'hCAA, 2'b01, 1'b1);
    n_chk++;
    if (out_frame_err !== 1'b0)
      $display("FAIL stop2_ok fe=%b want 0", out_frame_err);
    else n_pass++;
    pop1();
    send1(12'h4AB, 2'b01, 1'b0);
    n_chk++;
    if (out_frame_err !== 1'b1 || out_data !== 8'h55)
      $display("FAIL start_err fe=%b d=%h want 1 55",
               out_frame_err, out_data);
    else n_pass++;
    pop1();
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    parity_mode = 2'b00;
    two_stop = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      frame_in = mkf(8'(i));
      frame_valid = 1'b1;
      tick();
    end
    frame_valid = 1'b0;
    n_chk++;
    if (overrun !== 1'b0)
      $display("FAIL ovr_early ovr=%b want 0", overrun);
    else n_pass++;
    tick();
    n_chk++;
    if (overrun !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL ovr_set ovr=%b v=%b want 1 1", overrun, out_valid);
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== 8'(i))
        $display("FAIL ovr_pop%0d v=%b d=%h want 1 %h",
                 i, out_valid, out_data, 8'(i));
      else n_pass++;
      tick();
    end
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || overrun !== 1'b1)
      $display("FAIL ovr_drain v=%b ovr=%b want 0 1", out_valid, overrun);
    else n_pass++;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) begin
      frame_in = mkf(8'(8'h20 + i));
      frame_valid = 1'b1;
      tick();
    end
    frame_valid = 1'b0;
    tick();
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'h20)
      $display("FAIL clr_pre v=%b d=%h want 1 20", out_valid, out_data);
    else n_pass++;
    frame_in = mkf(8'h77);
    frame_valid = 1'b1;
    clear = 1'b1;
    tick();
    frame_valid = 1'b0;
    clear = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || overrun !== 1'b0)
      $display("FAIL clr_now v=%b ovr=%b want 0 0", out_valid, overrun);
    else n_pass++;
    tick();
    tick();
    n_chk++;
    if (out_valid !== 1'b0)
      $display("FAIL clr_discard v=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin
      frame_in = mkf(8'(8'h10 + i));
      frame_valid = 1'b1;
      tick();
    end
    frame_valid = 1'b0;
    tick();
    tick();
    frame_in = mkf(8'h14);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_chk++;
    if (overrun !== 1'b0 || out_data !== 8'h11)
      $display("FAIL fullpop ovr=%b d=%h want 0 11", overrun, out_data);
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + i))
        $display("FAIL fullpop_ord%0d v=%b d=%h want 1 %h",
                 i, out_valid, out_data, 8'(8'h10 + i));
      else n_pass++;
      tick();
    end
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0)
      $display("FAIL fullpop_cnt v=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      frame_in = {3'b010, 8'hF0, 1'b1};
      frame_valid = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || overrun !== 1'b0 || out_data !== 8'h00 ||
        out_parity_err !== 1'b0 || out_frame_err !== 1'b0)
      $display("FAIL mid_reset v=%b ovr=%b d=%h pe=%b fe=%b want 0 0 00 0 0",
               out_valid, overrun, out_data, out_parity_err, out_frame_err);
    else n_pass++;
    frame_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_chk++;
    if (out_valid !== 1'b0)
      $display("FAIL mid_reset_flush v=%b want 0", out_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_even();
    test_parity();
    test_frame_err();
    test_overrun();
    test_clear();
    test_full_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
